// File: rtl/command_frame_scheduler.sv
// command_frame_scheduler
//   Shares the command_translator between the vision pipeline and the
//   manual/safety override. One command is chosen per frame and held on
//   trans_cmd for the whole frame. The translator is paced one character at
//   a time into the UART. A minimum idle gap separates frames, and the last
//   command is re-sent as a heartbeat when no new frame has started for
//   HEARTBEAT_CYCLES clocks.
//
// Ports
//   clk, rst_n           system clock, synchronous active-low reset
//   vis_cmd/vis_valid    vision request (dropped if equal to the last command)
//   ovr_cmd/ovr_valid    override request (priority, never dropped)
//   trans_cmd            command held on the translator
//   trans_restart        pulse: translator rewinds to character 0
//   trans_step           pulse: translator emits its next character
//   trans_char(_ready)   character returned by the translator
//   uart_data/uart_start byte and load strobe for the UART
//   uart_busy            UART is transmitting
//   frame_active         high from trans_restart through the last busy fall
//   frame_done           pulse when a frame completes
//   frame_err            pulse when a frame is aborted on step timeout
module command_frame_scheduler #(
  parameter int unsigned FRAME_LEN        = 25,
  parameter int unsigned GAP_CYCLES       = 1000,
  parameter int unsigned HEARTBEAT_CYCLES = 5_000_000,
  parameter int unsigned STEP_TIMEOUT     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] vis_cmd,
  input  logic       vis_valid,
  input  logic [2:0] ovr_cmd,
  input  logic       ovr_valid,
  output logic [2:0] trans_cmd,
  output logic       trans_restart,
  output logic       trans_step,
  input  logic [7:0] trans_char,
  input  logic       trans_char_ready,
  output logic [7:0] uart_data,
  output logic       uart_start,
  input  logic       uart_busy,
  output logic       frame_active,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int unsigned CW = (FRAME_LEN > 1)        ? $clog2(FRAME_LEN)        : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1)       ? $clog2(GAP_CYCLES)       : 1;
  localparam int unsigned HW = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam int unsigned TW = (STEP_TIMEOUT > 1)     ? $clog2(STEP_TIMEOUT)     : 1;

  localparam logic [CW-1:0] CHAR_LAST = CW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [HW-1:0] HB_LAST   = HW'(HEARTBEAT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(STEP_TIMEOUT - 1);

  localparam logic [2:0] CMD_NEUTRAL = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STEP,
    S_CAPTURE,
    S_SEND,
    S_WAIT_TX,
    S_GAP
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      trans_cmd_q, trans_cmd_d;
  logic [2:0]      last_cmd_q, last_cmd_d;
  logic [2:0]      pend_cmd_q, pend_cmd_d;
  logic            pend_q, pend_d;
  logic            hb_pend_q, hb_pend_d;
  logic [HW-1:0]   hb_cnt_q, hb_cnt_d;
  logic [CW-1:0]   char_cnt_q, char_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            tx_first_q, tx_first_d;
  logic [7:0]      uart_data_q, uart_data_d;

  logic            hb_hit;
  logic            frame_start;
  logic [2:0]      sel_cmd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      trans_cmd_q <= CMD_NEUTRAL;
      last_cmd_q  <= CMD_NEUTRAL;
      pend_cmd_q  <= CMD_NEUTRAL;
      pend_q      <= 1'b1;
      hb_pend_q   <= 1'b0;
      hb_cnt_q    <= '0;
      char_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      tx_first_q  <= 1'b0;
      uart_data_q <= '0;
    end else begin
      state_q     <= state_d;
      trans_cmd_q <= trans_cmd_d;
      last_cmd_q  <= last_cmd_d;
      pend_cmd_q  <= pend_cmd_d;
      pend_q      <= pend_d;
      hb_pend_q   <= hb_pend_d;
      hb_cnt_q    <= hb_cnt_d;
      char_cnt_q  <= char_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      tx_first_q  <= tx_first_d;
      uart_data_q <= uart_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    trans_cmd_d   = trans_cmd_q;
    last_cmd_d    = last_cmd_q;
    pend_cmd_d    = pend_cmd_q;
    pend_d        = pend_q;
    hb_pend_d     = hb_pend_q;
    hb_cnt_d      = hb_cnt_q;
    char_cnt_d    = char_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    tx_first_d    = 1'b0;
    uart_data_d   = uart_data_q;
    trans_restart = 1'b0;
    trans_step    = 1'b0;
    uart_start    = 1'b0;
    frame_done    = 1'b0;
    frame_err     = 1'b0;
    frame_start   = 1'b0;
    sel_cmd       = last_cmd_q;

    // Heartbeat counter saturates at its terminal value until a frame starts.
    hb_hit = (hb_cnt_q == HB_LAST);
    if (hb_hit) begin
      hb_pend_d = 1'b1;
    end else begin
      hb_cnt_d = hb_cnt_q + HW'(1);
    end

    case (state_q)
      S_IDLE: begin
        // hb_hit is included so a heartbeat due while idle is not delayed a cycle.
        if (pend_q || hb_pend_q || hb_hit) begin
          state_d     = S_START;
          frame_start = 1'b1;
        end
      end
      S_START: begin
        trans_restart = 1'b1;
        state_d       = S_STEP;
      end
      S_STEP: begin
        trans_step = 1'b1;
        tmo_cnt_d  = '0;
        state_d    = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (trans_char_ready) begin
          uart_data_d = trans_char;
          state_d     = S_SEND;
        end else if (tmo_cnt_q == TMO_LAST) begin
          frame_err = 1'b1;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      S_SEND: begin
        uart_start = 1'b1;
        tx_first_d = 1'b1;
        state_d    = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        // The UART raises busy one clock after the load strobe, so the
        // first WAIT_TX cycle cannot see it yet.
        if (!tx_first_q && !uart_busy) begin
          if (char_cnt_q == CHAR_LAST) begin
            frame_done = 1'b1;
            gap_cnt_d  = '0;
            state_d    = S_GAP;
          end else begin
            char_cnt_d = char_cnt_q + CW'(1);
            state_d    = S_STEP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The frame command is latched on the edge into START so it is already
    // stable while trans_restart is high.
    if (frame_start) begin
      sel_cmd     = pend_q ? pend_cmd_q : last_cmd_q;
      trans_cmd_d = sel_cmd;
      last_cmd_d  = sel_cmd;
      pend_d      = 1'b0;
      hb_pend_d   = 1'b0;
      hb_cnt_d    = '0;
      char_cnt_d  = '0;
    end

    // Arbitration is applied last so a request coinciding with frame start
    // survives the clear and is kept for the next frame.
    if (ovr_valid) begin
      pend_cmd_d = ovr_cmd;
      pend_d     = 1'b1;
    end else if (vis_valid && (vis_cmd != last_cmd_d)) begin
      pend_cmd_d = vis_cmd;
      pend_d     = 1'b1;
    end
  end

  assign trans_cmd    = trans_cmd_q;
  assign uart_data    = uart_data_q;
  assign frame_active = (state_q != S_IDLE) && (state_q != S_GAP);

endmodule

// File: tb/tb_command_frame_scheduler.sv
module tb_command_frame_scheduler;

  localparam int FL   = 4;
  localparam int GAP  = 3;
  localparam int HB   = 200;
  localparam int TO   = 4;
  localparam int BUSY = 5;
  // step, translator ready, send, busy time, final busy-low sample
  localparam int P    = 1 + 1 + 1 + BUSY + 1;
  localparam int INF  = 32'h3fffffff;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] vis_cmd = 3'd0;
  logic       vis_valid = 1'b0;
  logic [2:0] ovr_cmd = 3'd0;
  logic       ovr_valid = 1'b0;
  logic [2:0] trans_cmd;
  logic       trans_restart;
  logic       trans_step;
  logic [7:0] trans_char = 8'd0;
  logic       trans_char_ready = 1'b0;
  logic [7:0] uart_data;
  logic       uart_start;
  logic       uart_busy;
  logic       frame_active;
  logic       frame_done;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  command_frame_scheduler #(
    .FRAME_LEN(FL),
    .GAP_CYCLES(GAP),
    .HEARTBEAT_CYCLES(HB),
    .STEP_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vis_cmd(vis_cmd),
    .vis_valid(vis_valid),
    .ovr_cmd(ovr_cmd),
    .ovr_valid(ovr_valid),
    .trans_cmd(trans_cmd),
    .trans_restart(trans_restart),
    .trans_step(trans_step),
    .trans_char(trans_char),
    .trans_char_ready(trans_char_ready),
    .uart_data(uart_data),
    .uart_start(uart_start),
    .uart_busy(uart_busy),
    .frame_active(frame_active),
    .frame_done(frame_done),
    .frame_err(frame_err)
  );

  // Translator: ready one clock after each step; character encodes cmd and index.
  logic [3:0] x_idx = 4'd0;
  logic       xlat_dead = 1'b0;
  always @(posedge clk) begin
    if (trans_restart) x_idx <= 4'd0;
    else if (trans_step) x_idx <= x_idx + 4'd1;
    trans_char_ready <= trans_step && !xlat_dead;
    if (trans_step) trans_char <= {1'b0, trans_cmd, x_idx};
  end

  // UART: busy for BUSY clocks after each load strobe.
  int b_cnt = 0;
  always @(posedge clk) begin
    if (uart_start) b_cnt <= BUSY;
    else if (b_cnt != 0) b_cnt <= b_cnt - 1;
  end
  assign uart_busy = (b_cnt != 0);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Observation of DUT events for the directed checks.
  int n_restart = 0, n_done = 0, n_err = 0, n_us_fr = 0;
  int last_rs_cyc = 0, last_done_cyc = 0, last_err_cyc = 0, last_step_cyc = 0;
  int rs_cmd = 0, first_ud = 0;
  always @(negedge clk) begin
    if (trans_restart === 1'b1) begin
      n_restart++; last_rs_cyc = cyc; rs_cmd = int'(trans_cmd); n_us_fr = 0;
    end
    if (trans_step === 1'b1) last_step_cyc = cyc;
    if (uart_start === 1'b1) begin
      if (n_us_fr == 0) first_ud = int'(uart_data);
      n_us_fr++;
    end
    if (frame_done === 1'b1) begin n_done++; last_done_cyc = cyc; end
    if (frame_err === 1'b1) begin n_err++; last_err_cyc = cyc; end
  end

  // Frame-level model: pending request, last command, and the earliest cycle
  // each source may start a frame; a started frame has a fixed schedule.
  int m_last = 1, m_pend = 1, m_pcmd = 1, m_tc = 1;
  int pend_ready = 0, gap_ready = 0, hb_ready = INF;
  int fS = 0, f_end = 0, f_cmd = 0;
  bit f_valid = 0, f_dead = 0, f_cancel = 0, chk_en = 0, rst_prev = 0;

  always @(negedge clk) begin
    int c, off, kk, pr, es;
    bit inf, e_rs, e_st, e_us, e_dn, e_er;
    logic [7:0] eu;
    c = cyc;
    if (chk_en) begin
      inf  = f_valid && (c >= fS) && (c <= f_end);
      off  = c - fS - 1;
      e_rs = inf && (c == fS);
      e_st = inf && (off >= 0) && (f_dead ? (off == 0) : ((off % P == 0) && (off / P < FL)));
      e_us = inf && !f_dead && (off >= 2) && ((off - 2) % P == 0) && ((off - 2) / P < FL);
      e_dn = f_valid && !f_dead && !f_cancel && (c == f_end);
      e_er = f_valid && f_dead && !f_cancel && (c == f_end);
      chk("trans_restart", int'(trans_restart), int'(e_rs));
      chk("trans_step", int'(trans_step), int'(e_st));
      chk("uart_start", int'(uart_start), int'(e_us));
      chk("frame_active", int'(frame_active), int'(inf));
      chk("frame_done", int'(frame_done), int'(e_dn));
      chk("frame_err", int'(frame_err), int'(e_er));
      chk("trans_cmd", int'(trans_cmd), m_tc);
      chk("strobe_onehot", int'($countones({trans_restart, trans_step, uart_start}) <= 1), 1);
      chk("done_err_excl", int'(frame_done && frame_err), 0);
      if (e_us) begin
        kk = (off - 2) / P;
        eu = {1'b0, f_cmd[2:0], kk[3:0]};
        chk("uart_data", int'(uart_data), int'(eu));
      end
      if (rst_prev) chk("reset_uart_data", int'(uart_data), 0);
    end

    rst_prev = 0;
    if (!rst_n) begin
      m_pend = 1; m_pcmd = 1; m_last = 1; m_tc = 1;
      pend_ready = c + 2; gap_ready = 0; hb_ready = c + 1 + HB;
      if (f_valid && f_end > c) begin f_end = c; f_cancel = 1; end
      rst_prev = 1; chk_en = 1;
    end else begin
      pr = m_pend ? pend_ready : INF;
      es = (pr < hb_ready) ? pr : hb_ready;
      if (gap_ready > es) es = gap_ready;
      if (es <= c + 1) begin
        f_cmd = m_pend ? m_pcmd : m_last;
        m_last = f_cmd; m_tc = f_cmd; m_pend = 0;
        fS = c + 1; f_valid = 1; f_cancel = 0; f_dead = xlat_dead;
        f_end = f_dead ? (fS + 1 + TO) : (fS + FL * P);
        gap_ready = f_end + GAP + 2;
        hb_ready = fS + HB;
      end
      if (ovr_valid) begin
        if (!m_pend) pend_ready = c + 2;
        m_pend = 1; m_pcmd = int'(ovr_cmd);
      end else if (vis_valid && int'(vis_cmd) != m_last) begin
        if (!m_pend) pend_ready = c + 2;
        m_pend = 1; m_pcmd = int'(vis_cmd);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input bit ov, input int oc, input bit vv, input int vc);
    ovr_valid = ov; ovr_cmd = 3'(oc); vis_valid = vv; vis_cmd = 3'(vc);
    tick(1);
    ovr_valid = 1'b0; vis_valid = 1'b0;
  endtask

  task automatic wait_rs(input int maxc);
    int n0 = n_restart;
    int k = 0;
    while (n_restart == n0 && k < maxc) begin tick(1); k++; end
    if (n_restart == n0) begin
      checks++; failures++;
      $display("FAIL wait_restart: got none expected one within %0d cycles", maxc);
    end
  endtask

  task automatic wait_done(input int maxc);
    int n0 = n_done;
    int k = 0;
    while (n_done == n0 && k < maxc) begin tick(1); k++; end
    if (n_done == n0) begin
      checks++; failures++;
      $display("FAIL wait_done: got none expected one within %0d cycles", maxc);
    end
  endtask

  task automatic wait_err(input int maxc);
    int n0 = n_err;
    int k = 0;
    while (n_err == n0 && k < maxc) begin tick(1); k++; end
    if (n_err == n0) begin
      checks++; failures++;
      $display("FAIL wait_err: got none expected one within %0d cycles", maxc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, p, d, hb_prev, n0, nd0, s;
    tick(3);
    chk("reset_trans_cmd", int'(trans_cmd), 1);
    chk("reset_frame_active", int'(frame_active), 0);
    rst_n = 1'b1; r = cyc;

    // Neutral frame after reset release.
    wait_rs(10);
    chk("first_restart_cycle", last_rs_cyc, r + 1);
    chk("first_cmd", rs_cmd, 1);
    wait_done(60);
    chk("first_frame_len", last_done_cyc - last_rs_cyc, 36);
    chk("first_ustarts", n_us_fr, 4);
    chk("first_done_count", n_done, 1);
    chk("first_last_char", int'(uart_data), 8'h13);
    tick(8);
    chk("idle_after_first", int'(frame_active), 0);

    // Vision request while idle; mid-frame change waits for the next frame.
    p = cyc;
    pulse(0, 0, 1, 0);
    wait_rs(10);
    chk("vis_latency", last_rs_cyc, p + 2);
    chk("vis_cmd0", rs_cmd, 0);
    tick(5);
    pulse(0, 0, 1, 1);
    wait_done(60);
    d = last_done_cyc;
    wait_rs(20);
    chk("gap_respected", int'(last_rs_cyc - d >= GAP + 1), 1);
    chk("next_cmd1", rs_cmd, 1);
    wait_done(60);
    tick(10);

    // Override beats vision; vision dedup; override repeat always sends.
    pulse(1, 2, 1, 4);
    wait_rs(10);
    chk("ovr_priority", rs_cmd, 2);
    wait_done(60);
    tick(10);
    n0 = n_restart;
    pulse(0, 0, 1, 2);
    tick(40);
    chk("vis_dedup", n_restart, n0);
    pulse(1, 2, 0, 0);
    wait_rs(10);
    chk("ovr_repeat", rs_cmd, 2);
    chk("ovr_repeat_count", n_restart, n0 + 1);
    wait_done(60);

    // Heartbeat re-sends the last command.
    hb_prev = last_rs_cyc;
    wait_rs(260);
    chk("hb_spacing", last_rs_cyc - hb_prev, 200);
    chk("hb_cmd", rs_cmd, 2);
    wait_done(60);
    tick(10);

    // Translator never ready: timeout, no UART byte, then GAP.
    xlat_dead = 1'b1;
    nd0 = n_done;
    pulse(1, 3, 0, 0);
    wait_rs(10);
    wait_err(20);
    xlat_dead = 1'b0;
    chk("err_delay", last_err_cyc - last_step_cyc, 4);
    chk("err_no_ustart", n_us_fr, 0);
    chk("err_no_done", n_done, nd0);
    pulse(1, 6, 0, 0);
    wait_rs(20);
    chk("err_gap_restart", last_rs_cyc - last_err_cyc, 5);
    chk("after_err_cmd", rs_cmd, 6);
    wait_done(60);
    tick(10);

    // Reset during WAIT_TX of character 2.
    pulse(1, 5, 0, 0);
    wait_rs(10);
    s = last_rs_cyc;
    while (cyc < s + 22) tick(1);
    chk("pre_reset_ustarts", n_us_fr, 3);
    rst_n = 1'b0;
    tick(1);
    chk("rst_uart_start", int'(uart_start), 0);
    chk("rst_trans_step", int'(trans_step), 0);
    chk("rst_restart", int'(trans_restart), 0);
    chk("rst_trans_cmd", int'(trans_cmd), 1);
    tick(7);
    rst_n = 1'b1;
    wait_rs(10);
    chk("post_rst_cmd", rs_cmd, 1);
    wait_done(60);
    chk("post_rst_first_char", first_ud, 8'h10);
    chk("post_rst_ustarts", n_us_fr, 4);
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/command_frame_scheduler.md
# command_frame_scheduler

Sequences the command_translator and shares it between two command requesters: the vision pipeline and the manual/safety override. It picks one command per frame, freezes it on the translator for the whole frame, and paces the translator one character at a time into the UART transmitter. It also enforces a minimum inter-frame gap and re-sends the last command as a heartbeat. The block sits between the vision/override logic and the command_translator + UART TX pair.

## Interface
- FRAME_LEN, 25: characters per JSON frame.
- GAP_CYCLES, 1000: minimum idle clocks between the end of one frame and the start of the next.
- HEARTBEAT_CYCLES, 5_000_000: clocks between frame starts after which the last command is re-sent.
- STEP_TIMEOUT, 4: clocks allowed from trans_step to trans_char_ready.
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  synchronous reset, active-low.
- vis_cmd  in  3  vision command.
- vis_valid  in  1  vis_cmd is valid this cycle.
- ovr_cmd  in  3  override command.
- ovr_valid  in  1  ovr_cmd is valid this cycle.
- trans_cmd  out  3  command held on the translator.
- trans_restart  out  1  one-cycle pulse; the translator rewinds to character 0.
- trans_step  out  1  one-cycle pulse; the translator emits its next character.
- trans_char  in  8  character from the translator.
- trans_char_ready  in  1  trans_char is valid this cycle.
- uart_data  out  8  byte to the UART.
- uart_start  out  1  one-cycle pulse; the UART loads uart_data.
- uart_busy  in  1  the UART is transmitting.
- frame_active  out  1  high from trans_restart through the last byte's busy fall.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_err  out  1  one-cycle pulse when a frame is aborted on step timeout.

## Operation
- **Arbitration** (every cycle):
  - ovr_valid has priority over vis_valid.
  - The winner is written to pend_cmd and sets pend.
  - A later request overwrites pend_cmd; the latest one wins.
- **Dedup:**
  - A vision request equal to last_cmd is ignored. It does not set pend.
  - An override request always sets pend.
- **Heartbeat:**
  - hb_cnt resets at every frame start.
  - When hb_cnt reaches HEARTBEAT_CYCLES-1, hb_pend is set. hb_pend uses last_cmd.
  - If pend is also set, pend takes precedence.
- **States:**
  - IDLE: when pend or hb_pend is set, go to START.
  - START:
    - Latch trans_cmd and last_cmd from pend_cmd (or from last_cmd on a heartbeat).
    - Clear pend/hb_pend and char_cnt=0.
    - Pulse trans_restart and go to STEP.
  - STEP: pulse trans_step, clear the timeout counter, go to CAPTURE.
  - CAPTURE:
    - On trans_char_ready, register uart_data<=trans_char and go to SEND.
    - If STEP_TIMEOUT cycles pass with no ready, pulse frame_err and go to GAP.
  - SEND: pulse uart_start, go to WAIT_TX.
  - WAIT_TX:
    - uart_busy is ignored in the first cycle; it is sampled from the second cycle on.
    - On busy low, char_cnt++.
    - If char_cnt==FRAME_LEN-1, pulse frame_done and go to GAP; otherwise go to STEP.
  - GAP: count GAP_CYCLES clocks, then go to IDLE.
- trans_cmd is stable from START to the end of the frame. Requests that arrive mid-frame or in GAP only update pend_cmd.
- Counter widths are $clog2 of their parameter (minimum 1). No counter wraps; each is cleared explicitly.

## Timing
- **Reset values:**
  - All outputs are 0, except trans_cmd=3'd1 (neutral).
  - last_cmd=3'd1, pend=1, pend_cmd=3'd1, hb_cnt=0, state=IDLE.
  - A neutral frame therefore starts on the first clock after rst_n rises.
- Reset asserted mid-frame:
  - The block returns to the reset state on the next edge.
  - uart_start and trans_step drop immediately.
  - The partial frame is not resumed.
- **Latency:**
  - Request to trans_restart: 2 cycles when IDLE (capture, then START).
  - Per character: STEP, plus translator latency, plus 1 (SEND), plus UART busy time, plus 1.
- Simultaneous ovr_valid and vis_valid → ovr_cmd is taken.
- A request arriving in the same cycle as START is kept for the next frame.
- frame_done and frame_err are mutually exclusive. At most one of trans_restart, trans_step, uart_start is high in any cycle.

## Test plan
All scenarios use FRAME_LEN=4, GAP_CYCLES=3, HEARTBEAT_CYCLES=200, STEP_TIMEOUT=4, a translator model with 1-cycle ready, and a UART model busy for 5 cycles.
- Reset release → frame with trans_cmd=1; exactly 4 uart_start pulses; frame_done once; then IDLE.
- vis_cmd=0 pulse while IDLE → trans_restart 2 cycles later. trans_cmd=0 holds for the frame even though vis_cmd=1 is applied mid-frame. The next frame is cmd 1, starting no earlier than 3 cycles after frame_done.
- ovr_valid(cmd=2) and vis_valid(cmd=4) in the same cycle → frame carries cmd 2. Repeating vis_cmd=2 afterwards → no new frame. Repeating ovr_cmd=2 → a new frame.
- No requests for 200 cycles after a frame start → heartbeat frame with the same last_cmd.
- Translator never asserts trans_char_ready → frame_err pulses 4 cycles after trans_step, the block passes through GAP, and there is no uart_start for that character.
- rst_n low during WAIT_TX of character 2 → all strobes 0 next cycle. After release, a fresh neutral frame starts from character 0 (trans_restart seen).
